// File: rtl/bench_pkg.sv
// bench_pkg: shared state encoding and default mailbox addresses for the bring-up monitor
package bench_pkg;
  typedef enum logic [2:0] {HOLD, RUN, PASS, FAIL, TIMEOUT} benchState_t;
  localparam logic [55:0] DEFAULT_TOHOST_ADDR = 56'h1000;
  localparam logic [55:0] DEFAULT_CONSOLE_ADDR = 56'h1008;
endpackage

// File: rtl/bench_monitor_if.sv
// bench_monitor_if: core-to-RAM write bus as seen by the monitor
interface bench_monitor_if #(
  parameter int ADDR_WIDTH = 56,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] addressBus;
  logic [DATA_WIDTH-1:0] dataOut;
  logic enableWrite;
  modport master (output addressBus, dataOut, enableWrite);
  modport slave (input addressBus, dataOut, enableWrite);
endinterface

// File: rtl/sat_counter.sv
// sat_counter: up-counter with enable and sync clear that sticks at all-ones
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);
  logic [WIDTH-1:0] count_q;
  // count up when enabled, never wrapping past all-ones
  always_ff @(posedge clk) begin
    if (clr_i) count_q <= '0;
    else if (en_i && count_q != '1) count_q <= count_q + 1'b1;
  end
  assign count_o = count_q;
endmodule

// File: rtl/bench_monitor.sv
// bench_monitor: sequences core reset, snoops the write bus and decides pass/fail/timeout
module bench_monitor
  import bench_pkg::*;
#(
  parameter int ADDR_WIDTH = 56,
  parameter int DATA_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR = ADDR_WIDTH'(DEFAULT_TOHOST_ADDR),
  parameter logic [ADDR_WIDTH-1:0] CONSOLE_ADDR = ADDR_WIDTH'(DEFAULT_CONSOLE_ADDR),
  parameter int RESET_CYCLES = 3,
  parameter int MAX_CYCLES = 100,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  bench_monitor_if.slave        bus,
  output logic                  coreRst,
  output logic                  done,
  output logic                  pass,
  output logic                  timedOut,
  output logic [DATA_WIDTH-2:0] failCode,
  output logic [CNT_WIDTH-1:0]  cycleCount,
  output logic [CNT_WIDTH-1:0]  writeCount,
  output logic                  consoleValid,
  output logic [7:0]            consoleByte
);
  benchState_t state_q;
  logic core_rst_q, done_q, pass_q, timed_out_q, console_valid_q;
  logic [DATA_WIDTH-2:0] fail_code_q;
  logic [7:0] console_byte_q;
  logic [CNT_WIDTH-1:0] hold_cnt;
  logic hold_d, run_d, wr_d, tohost_d, console_d, ok_d;
  assign hold_d = state_q == HOLD;
  assign run_d = state_q == RUN;
  assign wr_d = run_d & bus.enableWrite;
  assign tohost_d = wr_d & (bus.addressBus == TOHOST_ADDR);
  assign console_d = wr_d & (bus.addressBus == CONSOLE_ADDR);
  assign ok_d = bus.dataOut == DATA_WIDTH'(1);
  sat_counter #(.WIDTH(CNT_WIDTH)) u_hold (
    .clk(clk), .clr_i(rst), .en_i(hold_d), .count_o(hold_cnt)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle (
    .clk(clk), .clr_i(rst), .en_i(run_d), .count_o(cycleCount)
  );
  sat_counter #(.WIDTH(CNT_WIDTH)) u_write (
    .clk(clk), .clr_i(rst), .en_i(wr_d), .count_o(writeCount)
  );
  // state machine with registered verdict and console outputs; a tohost write beats timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HOLD;
      core_rst_q <= 1'b1;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      timed_out_q <= 1'b0;
      fail_code_q <= '0;
      console_valid_q <= 1'b0;
      console_byte_q <= '0;
    end else begin
      console_valid_q <= console_d;
      if (console_d) console_byte_q <= bus.dataOut[7:0];
      case (state_q)
        HOLD: if (hold_cnt == CNT_WIDTH'(RESET_CYCLES - 1)) begin
          state_q <= RUN;
          core_rst_q <= 1'b0;
        end
        RUN: if (tohost_d && ok_d) begin
          state_q <= PASS;
          core_rst_q <= 1'b1;
          done_q <= 1'b1;
          pass_q <= 1'b1;
        end else if (tohost_d && bus.dataOut[0]) begin
          state_q <= FAIL;
          core_rst_q <= 1'b1;
          done_q <= 1'b1;
          fail_code_q <= bus.dataOut[DATA_WIDTH-1:1];
        end else if (cycleCount == CNT_WIDTH'(MAX_CYCLES - 1)) begin
          state_q <= TIMEOUT;
          core_rst_q <= 1'b1;
          done_q <= 1'b1;
          timed_out_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign coreRst = core_rst_q;
  assign done = done_q;
  assign pass = pass_q;
  assign timedOut = timed_out_q;
  assign failCode = fail_code_q;
  assign consoleValid = console_valid_q;
  assign consoleByte = console_byte_q;
endmodule

// File: tb/tb_bench_monitor.sv
// tb_bench_monitor: directed self-checking bench for bench_monitor
module tb_bench_monitor;
  logic clk, rst;
  logic coreRst, done, pass, timedOut, consoleValid;
  logic [62:0] failCode;
  logic [31:0] cycleCount, writeCount;
  logic [7:0] consoleByte;
  int n_checks = 0;
  int n_fail = 0;
  bench_monitor_if #(.ADDR_WIDTH(56), .DATA_WIDTH(64)) bus_if ();
  bench_monitor dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .coreRst(coreRst), .done(done), .pass(pass), .timedOut(timedOut),
    .failCode(failCode), .cycleCount(cycleCount), .writeCount(writeCount),
    .consoleValid(consoleValid), .consoleByte(consoleByte)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_bus();
    bus_if.enableWrite = 1'b0;
    bus_if.addressBus = '0;
    bus_if.dataOut = '0;
  endtask
  task automatic drive(input logic [55:0] a, input logic [63:0] d);
    bus_if.enableWrite = 1'b1;
    bus_if.addressBus = a;
    bus_if.dataOut = d;
  endtask
  task automatic wr(input logic [55:0] a, input logic [63:0] d);
    drive(a, d);
    tick();
    idle_bus();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  // busy drives a passing tohost write throughout reset and hold: it must be ignored
  task automatic do_reset(input bit busy);
    if (busy) drive(56'h1000, 64'h1);
    else idle_bus();
    rst = 1'b1;
    tick();
    tick();
    check("rst_corerst", coreRst, 1);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_timeout", timedOut, 0);
    check("rst_failcode", failCode, 0);
    check("rst_cycles", cycleCount, 0);
    check("rst_writes", writeCount, 0);
    check("rst_cvalid", consoleValid, 0);
    check("rst_cbyte", consoleByte, 0);
    rst = 1'b0;
    tick();
    check("hold1_corerst", coreRst, 1);
    tick();
    check("hold2_corerst", coreRst, 1);
    tick();
    idle_bus();
    check("run_corerst", coreRst, 0);
    check("run_cycles0", cycleCount, 0);
    check("run_writes0", writeCount, 0);
    check("run_done0", done, 0);
  endtask
  initial begin
    rst = 1'b1;
    idle_bus();
    do_reset(0);
    idle(10);
    check("pre_pass_cycles", cycleCount, 10);
    wr(56'h1000, 64'h1);
    check("pass_done", done, 1);
    check("pass_pass", pass, 1);
    check("pass_cycles", cycleCount, 11);
    check("pass_corerst", coreRst, 1);
    check("pass_writes", writeCount, 1);
    check("pass_timeout", timedOut, 0);
    wr(56'h1008, 64'h41);
    tick();
    check("term_cycles", cycleCount, 11);
    check("term_writes", writeCount, 1);
    check("term_cvalid", consoleValid, 0);
    check("term_pass", pass, 1);
    do_reset(1);
    wr(56'h1000, 64'h2);
    check("even_done", done, 0);
    check("even_writes", writeCount, 1);
    wr(56'h1000, 64'h7);
    check("fail_done", done, 1);
    check("fail_pass", pass, 0);
    check("fail_code", failCode, 3);
    check("fail_writes", writeCount, 2);
    check("fail_corerst", coreRst, 1);
    do_reset(0);
    wr(56'h1008, 64'hFF48);
    check("con_h_valid", consoleValid, 1);
    check("con_h_byte", consoleByte, 8'h48);
    wr(56'h1008, 64'h69);
    check("con_i_valid", consoleValid, 1);
    check("con_i_byte", consoleByte, 8'h69);
    tick();
    check("con_idle_valid", consoleValid, 0);
    check("con_writes", writeCount, 2);
    check("con_done", done, 0);
    wr(56'h1001000, 64'h1);
    check("addr_full_done", done, 0);
    idle(3);
    check("mid_cycles", cycleCount, 7);
    do_reset(0);
    idle(99);
    check("pre_to_cycles", cycleCount, 99);
    check("pre_to_done", done, 0);
    tick();
    check("to_timeout", timedOut, 1);
    check("to_done", done, 1);
    check("to_pass", pass, 0);
    check("to_cycles", cycleCount, 100);
    tick();
    check("to_frozen", cycleCount, 100);
    do_reset(0);
    idle(99);
    wr(56'h1000, 64'h1);
    check("late_pass", pass, 1);
    check("late_timeout", timedOut, 0);
    check("late_cycles", cycleCount, 100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
